// File: rtl/spi_xfer_pkg.sv
// Shared types and defaults for the two-requester SPI burst arbiter.
// The state encoding is also visible to checkers through the top-level state port.
package spi_xfer_pkg;

    localparam int LEN_W_DEF   = 8;
    localparam int GAP_CYC_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_XFER      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } xfer_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        onehot2 = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the priority pointer moves to the other
// requester whenever the current owner releases the resource.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       rel_strobe,
    input  logic       rel_idx,
    output logic       win_valid,
    output logic       win_idx
);

    logic ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (rel_strobe) begin
            ptr <= ~rel_idx;
        end
    end

    always_comb begin
        win_valid = |req;
        win_idx   = 1'b0;
        case (req)
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ptr;
            default: win_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one spi_master between two requesters: round-robin grant, burst
// sequencing of TX bytes, and routing of RX bytes / completion to the owner.
module spi_xfer_arbiter
    import spi_xfer_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req,
    input  logic [2*LEN_W-1:0]   req_len,
    input  logic [15:0]          tx_data,
    output logic [1:0]           tx_next,
    output logic [7:0]           rx_data,
    output logic [1:0]           rx_valid,
    output logic [1:0]           done,
    output logic [1:0]           grant,
    output logic                 mst_start,
    output logic [7:0]           mst_thr,
    output logic                 mst_last,
    input  logic                 mst_txrdy,
    input  logic                 mst_rxrdy,
    input  logic [7:0]           mst_rhr,
    input  logic                 mst_done,
    output xfer_state_e          state
);

    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    // Requester handshake: tx_next[k] is a one-cycle pulse meaning the byte on
    // tx_data[k] was taken and the next one must be presented by the following
    // clock; rx_valid[k] and done[k] are one-cycle pulses with no back-pressure.
    xfer_state_e      state_d;
    logic             owner;
    logic [LEN_W-1:0] tx_cnt;
    logic [LEN_W-1:0] rx_cnt;
    logic [LEN_W-1:0] len_sel;
    logic [7:0]       gap_cnt;
    logic [7:0]       tx_byte;
    logic             arb_valid;
    logic             arb_idx;
    logic             busy;
    logic             do_load;
    logic             do_tx;
    logic             do_rx;
    logic             rx_last;
    logic             do_end;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .rel_strobe (do_end),
        .rel_idx    (owner),
        .win_valid  (arb_valid),
        .win_idx    (arb_idx)
    );

    assign len_sel = arb_idx ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    assign tx_byte = owner ? tx_data[15:8] : tx_data[7:0];

    // An early mst_done is taken as completion so a confused master cannot hang the bus.
    always_comb begin
        busy    = (state == ST_LOAD) || (state == ST_XFER) || (state == ST_WAIT_DONE);
        do_load = (state == ST_LOAD) && (tx_cnt != '0);
        do_tx   = (state == ST_XFER) && mst_txrdy && (tx_cnt != '0);
        do_rx   = busy && mst_rxrdy && (rx_cnt != '0);
        rx_last = do_rx && (rx_cnt == ONE);
        do_end  = ((state == ST_LOAD) && (tx_cnt == '0)) ||
                  (((state == ST_XFER) || (state == ST_WAIT_DONE)) && mst_done);
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:      if (arb_valid) state_d = ST_LOAD;
            ST_LOAD:      state_d = (tx_cnt == '0) ? ST_GAP : ST_XFER;
            ST_XFER: begin
                if (do_end)       state_d = ST_GAP;
                else if (rx_last) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (mst_done) state_d = ST_GAP;
            ST_GAP:       if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant     <= 2'b00;
            owner     <= 1'b0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            gap_cnt   <= 8'd0;
            mst_thr   <= 8'h00;
            mst_last  <= 1'b0;
            mst_start <= 1'b0;
            tx_next   <= 2'b00;
            rx_data   <= 8'h00;
            rx_valid  <= 2'b00;
            done      <= 2'b00;
        end else begin
            tx_next   <= 2'b00;
            rx_valid  <= 2'b00;
            done      <= 2'b00;
            mst_start <= 1'b0;
            gap_cnt   <= (state == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;

            if ((state == ST_IDLE) && arb_valid) begin
                grant  <= onehot2(arb_idx);
                owner  <= arb_idx;
                tx_cnt <= len_sel;
                rx_cnt <= len_sel;
            end

            if (do_load || do_tx) begin
                mst_thr   <= tx_byte;
                mst_last  <= (tx_cnt == ONE);
                mst_start <= do_load;
                tx_next   <= onehot2(owner);
                tx_cnt    <= tx_cnt - ONE;
            end

            if (do_rx) begin
                rx_data  <= mst_rhr;
                rx_valid <= onehot2(owner);
                rx_cnt   <= rx_cnt - ONE;
            end

            if (do_end) begin
                done  <= onehot2(owner);
                grant <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a cycle-stepped requester and
// spi_master model; every DUT observation is checked against bench expectations.
module tb_spi_xfer_arbiter;
    import spi_xfer_pkg::*;

    localparam int LEN_W   = 8;
    localparam int GAP_CYC = 4;
    localparam int SHIFT   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [15:0]   req_len = 16'h0000;
    logic [15:0]   tx_data = 16'h0000;
    logic [1:0]    tx_next;
    logic [7:0]    rx_data;
    logic [1:0]    rx_valid;
    logic [1:0]    done;
    logic [1:0]    grant;
    logic          mst_start;
    logic [7:0]    mst_thr;
    logic          mst_last;
    logic          mst_txrdy = 1'b0;
    logic          mst_rxrdy = 1'b0;
    logic [7:0]    mst_rhr = 8'h00;
    logic          mst_done = 1'b0;
    xfer_state_e   state;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(.LEN_W(LEN_W), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_len   (req_len),
        .tx_data   (tx_data),
        .tx_next   (tx_next),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .done      (done),
        .grant     (grant),
        .mst_start (mst_start),
        .mst_thr   (mst_thr),
        .mst_last  (mst_last),
        .mst_txrdy (mst_txrdy),
        .mst_rxrdy (mst_rxrdy),
        .mst_rhr   (mst_rhr),
        .mst_done  (mst_done),
        .state     (state)
    );

    int checks = 0;
    int errors = 0;
    int tick_n = 0;
    int end_tick = -1000;

    logic [7:0] src [2][256];
    logic [7:0] idx [2];
    logic [7:0] exp_idx [2];
    logic       hold [2];

    logic [7:0] exp_thr_q[$];
    logic       exp_last_q[$];
    logic [7:0] exp_rx_q[$];
    logic [1:0] exp_done_q[$];

    int n_txnext [2];
    int n_rxvalid [2];
    int n_done [2];
    int n_start;
    int n_last;

    logic       m_busy;
    logic       m_last;
    logic [7:0] m_byte;
    int         m_cnt;
    int         m_done_cnt;
    int         m_done_tick;
    logic       fast_done = 1'b0;

    function automatic logic [1:0] oh(input int k);
        return (k == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_tx_data();
        tx_data = {src[1][idx[1]], src[0][idx[0]]};
    endtask

    task automatic clear_model();
        m_busy      = 1'b0;
        m_last      = 1'b0;
        m_byte      = 8'h00;
        m_cnt       = 0;
        m_done_cnt  = 0;
        m_done_tick = -1;
        mst_txrdy   = 1'b0;
        mst_rxrdy   = 1'b0;
        mst_done    = 1'b0;
        mst_rhr     = 8'h00;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            n_txnext[k]  = 0;
            n_rxvalid[k] = 0;
            n_done[k]    = 0;
        end
        n_start = 0;
        n_last  = 0;
    endtask

    task automatic flush_expect();
        exp_thr_q.delete();
        exp_last_q.delete();
        exp_rx_q.delete();
        exp_done_q.delete();
        exp_idx[0] = idx[0];
        exp_idx[1] = idx[1];
    endtask

    task automatic expect_burst(input int k, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = src[k][exp_idx[k]];
            exp_thr_q.push_back(b);
            exp_last_q.push_back(i == n - 1);
            exp_rx_q.push_back(~b);
            exp_idx[k] = exp_idx[k] + 8'd1;
        end
        exp_done_q.push_back(oh(k));
    endtask

    // One clock step: observe DUT at the falling edge, then update requesters and master.
    task automatic tick();
        @(negedge clk);
        tick_n++;
        if (tx_next != 2'b00) begin
            if (exp_thr_q.size() == 0) begin
                check("tx_next_unexpected", tx_next, 2'b00);
            end else begin
                check("tx_next_owner", tx_next, exp_done_q[0]);
                check("mst_thr", mst_thr, exp_thr_q.pop_front());
                check("mst_last", mst_last, exp_last_q.pop_front());
            end
            for (int k = 0; k < 2; k++) if (tx_next[k]) n_txnext[k]++;
            if (mst_last) n_last++;
        end
        if (rx_valid != 2'b00) begin
            if (exp_rx_q.size() == 0) begin
                check("rx_valid_unexpected", rx_valid, 2'b00);
            end else begin
                check("rx_valid_owner", rx_valid, exp_done_q[0]);
                check("rx_data", rx_data, exp_rx_q.pop_front());
            end
            for (int k = 0; k < 2; k++) if (rx_valid[k]) n_rxvalid[k]++;
        end
        if (done != 2'b00) begin
            if (exp_done_q.size() == 0) check("done_unexpected", done, 2'b00);
            else                        check("done_owner", done, exp_done_q.pop_front());
            check("done_grant_clear", grant, 2'b00);
            if (m_done_tick >= 0) begin
                check("done_latency", tick_n - m_done_tick, 1);
                m_done_tick = -1;
            end
            end_tick = tick_n - 1;
            for (int k = 0; k < 2; k++) begin
                if (done[k]) begin
                    n_done[k]++;
                    if (!hold[k]) req[k] = 1'b0;
                end
            end
        end
        if (mst_start) begin
            n_start++;
            check("start_gap", (tick_n - end_tick) >= GAP_CYC + 3, 1'b1);
        end

        for (int k = 0; k < 2; k++) if (tx_next[k]) idx[k] = idx[k] + 8'd1;
        drive_tx_data();

        mst_txrdy = 1'b0;
        mst_rxrdy = 1'b0;
        mst_done  = 1'b0;
        if (m_done_cnt > 0) begin
            m_done_cnt--;
            if (m_done_cnt == 0) begin
                mst_done    = 1'b1;
                m_done_tick = tick_n;
            end
        end
        if (mst_start) begin
            m_busy    = 1'b1;
            m_byte    = mst_thr;
            m_last    = mst_last;
            m_cnt     = SHIFT;
            mst_txrdy = 1'b1;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                mst_rxrdy = 1'b1;
                mst_rhr   = ~m_byte;
                if (m_last) begin
                    m_busy = 1'b0;
                    if (fast_done) begin
                        mst_done    = 1'b1;
                        m_done_tick = tick_n;
                    end else begin
                        m_done_cnt = 2;
                    end
                end else begin
                    m_byte    = mst_thr;
                    m_last    = mst_last;
                    mst_txrdy = 1'b1;
                    m_cnt     = SHIFT;
                end
            end
        end
    endtask

    task automatic run_until_drained(input int budget, input string tag);
        int n = 0;
        while (exp_done_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, exp_done_q.size(), 0);
        check({tag, "_thr_left"}, exp_thr_q.size(), 0);
        check({tag, "_rx_left"}, exp_rx_q.size(), 0);
    endtask

    task automatic settle(input string tag);
        repeat (GAP_CYC) tick();
        check({tag, "_idle_state"}, state, ST_IDLE);
        check({tag, "_idle_grant"}, grant, 2'b00);
    endtask

    task automatic do_reset();
        req   = 2'b00;
        reset = 1'b0;
        clear_model();
        flush_expect();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) src[k][i] = 8'(i * 37 + k * 91 + 5);
            idx[k]     = 8'd0;
            exp_idx[k] = 8'd0;
            hold[k]    = 1'b0;
        end
        src[0][0] = 8'hA1;
        src[0][1] = 8'hB2;
        src[0][2] = 8'hC3;
        drive_tx_data();
        clear_model();
        clear_counts();

        // Reset values
        reset = 1'b0;
        tick();
        tick();
        check("rst_grant", grant, 2'b00);
        check("rst_tx_next", tx_next, 2'b00);
        check("rst_rx_valid", rx_valid, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_mst_start", mst_start, 1'b0);
        check("rst_mst_thr", mst_thr, 8'h00);
        check("rst_mst_last", mst_last, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_state", state, ST_IDLE);
        reset = 1'b1;
        tick();

        // Single 3-byte burst on requester 0
        clear_counts();
        req_len[7:0] = 8'd3;
        expect_burst(0, 3);
        exp_rx_q.delete();
        exp_rx_q.push_back(8'h5E);
        exp_rx_q.push_back(8'h4D);
        exp_rx_q.push_back(8'h3C);
        req = 2'b01;
        tick();
        check("s1_grant", grant, 2'b01);
        check("s1_start_early", mst_start, 1'b0);
        tick();
        check("s1_start", mst_start, 1'b1);
        run_until_drained(100, "s1");
        check("s1_tx_next_cnt", n_txnext[0], 3);
        check("s1_rx_valid_cnt", n_rxvalid[0], 3);
        check("s1_done_cnt", n_done[0], 1);
        check("s1_last_cnt", n_last, 1);
        settle("s1");

        // Contention from reset, both held: strict alternation 0,1,0,1
        do_reset();
        clear_counts();
        req_len = {8'd2, 8'd2};
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        expect_burst(0, 2);
        expect_burst(1, 2);
        expect_burst(0, 2);
        expect_burst(1, 2);
        req = 2'b11;
        tick();
        check("s2_first_grant", grant, 2'b01);
        run_until_drained(300, "s2");
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        req = 2'b00;
        check("s2_done0_cnt", n_done[0], 2);
        check("s2_done1_cnt", n_done[1], 2);
        check("s2_tx1_cnt", n_txnext[1], 4);
        settle("s2");

        // Zero-length burst on requester 1
        clear_counts();
        req_len = {8'd0, 8'd5};
        exp_done_q.push_back(2'b10);
        req = 2'b10;
        tick();
        check("s3_grant", grant, 2'b10);
        run_until_drained(20, "s3");
        check("s3_no_start", n_start, 0);
        check("s3_no_tx_next", n_txnext[1], 0);
        check("s3_done_cnt", n_done[1], 1);
        settle("s3");

        // Maximum-length burst
        clear_counts();
        req_len = {8'd0, 8'd255};
        expect_burst(0, 255);
        req = 2'b01;
        run_until_drained(1500, "s4");
        check("s4_tx_next_cnt", n_txnext[0], 255);
        check("s4_rx_valid_cnt", n_rxvalid[0], 255);
        check("s4_last_cnt", n_last, 1);
        check("s4_done_cnt", n_done[0], 1);
        settle("s4");

        // Reset after the second received byte of a 4-byte burst
        clear_counts();
        req_len = {8'd0, 8'd4};
        expect_burst(0, 4);
        req = 2'b01;
        for (int n = 0; n < 60 && n_rxvalid[0] < 2; n++) tick();
        check("s5_reached_rx2", n_rxvalid[0], 2);
        reset = 1'b0;
        #1;
        check("s5_rst_grant", grant, 2'b00);
        check("s5_rst_tx_next", tx_next, 2'b00);
        check("s5_rst_rx_valid", rx_valid, 2'b00);
        check("s5_rst_done", done, 2'b00);
        check("s5_rst_mst_start", mst_start, 1'b0);
        check("s5_rst_mst_thr", mst_thr, 8'h00);
        check("s5_rst_mst_last", mst_last, 1'b0);
        check("s5_rst_rx_data", rx_data, 8'h00);
        check("s5_rst_state", state, ST_IDLE);
        do_reset();
        clear_counts();
        req_len = {8'd1, 8'd2};
        expect_burst(0, 2);
        expect_burst(1, 1);
        req = 2'b11;
        tick();
        check("s5_restart_grant", grant, 2'b01);
        run_until_drained(200, "s5");
        check("s5_done0_cnt", n_done[0], 1);
        check("s5_done1_cnt", n_done[1], 1);
        settle("s5");

        // req dropped mid-burst, overlapping txrdy/rxrdy, mst_done with the last rxrdy
        clear_counts();
        fast_done = 1'b1;
        req_len = {8'd4, 8'd0};
        expect_burst(1, 4);
        req = 2'b10;
        for (int n = 0; n < 30 && n_txnext[1] < 2; n++) tick();
        check("s6_reached_tx2", n_txnext[1], 2);
        req = 2'b00;
        run_until_drained(100, "s6");
        check("s6_tx_next_cnt", n_txnext[1], 4);
        check("s6_rx_valid_cnt", n_rxvalid[1], 4);
        check("s6_done_cnt", n_done[1], 1);
        fast_done = 1'b0;
        settle("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
